rect_fill_axi_master: RTL and testbench
=======================================

Name: rect_fill_axi_master

Overview:
- Parametrised AXI4 burst write master that fills a rectangle in a frame buffer with a solid colour, a horizontal gradient or a checkerboard.
- Successor to the single-beat test master driven from the graphics AXI-Lite register file.
- Adds configurable data width, burst length, row stride, fill modes and 4 KB-boundary burst splitting.
- Sits between the graphics control registers (cfg_*, start) and the memory-side AXI interconnect.

Parameters:
- ADDR_W, 32, AXI address width.
- DATA_W, 32, AXI data width; one pixel per beat; power of two, 32..128.
- MAX_BURST, 16, maximum beats per burst (1..256).
- DIM_W, 16, width of the cfg_width and cfg_height counters.
- CHK_SHIFT, 3, log2 of the checkerboard square size in pixels.

Ports:
- aclk  in  1  clock; all logic on rising edge.
- areset  in  1  synchronous reset, active-high.
- start  in  1  one-cycle pulse; latches all cfg_* inputs and begins a fill.
- cfg_base_addr  in  ADDR_W  byte address of pixel (0,0); low log2(DATA_W/8) bits are forced to 0.
- cfg_width  in  DIM_W  pixels per row.
- cfg_height  in  DIM_W  number of rows.
- cfg_stride  in  ADDR_W  bytes between row starts.
- cfg_mode  in  2  0 = solid, 1 = gradient, 2 = checkerboard, 3 = solid.
- cfg_color  in  DATA_W  primary colour.
- cfg_color2  in  DATA_W  checkerboard alternate colour.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle completion pulse.
- err  out  1  sticky SLVERR/DECERR flag; cleared by the next accepted start.
- m_axi_awaddr  out  ADDR_W
- m_axi_awlen  out  8
- m_axi_awsize  out  3
- m_axi_awburst  out  2
- m_axi_awvalid  out  1
- m_axi_awready  in  1
- m_axi_wdata  out  DATA_W
- m_axi_wstrb  out  DATA_W/8
- m_axi_wlast  out  1
- m_axi_wvalid  out  1
- m_axi_wready  in  1
- m_axi_bresp  in  2
- m_axi_bvalid  in  1
- m_axi_bready  out  1

Behaviour:
- Reset values: busy, done, err, all valids, bready and wlast = 0; awaddr, awlen, wdata = 0; state = IDLE.
- Constant outputs: awsize = log2(DATA_W/8); awburst = INCR; wstrb = all ones.
- FSM states: IDLE, CALC, ADDR, DATA, RESP, DONE.
- IDLE:
  - start latches the config and clears err.
  - If width or height is 0, go to DONE with no AXI traffic; otherwise go to CALC.
  - start while not in IDLE is ignored.
- CALC (1 cycle): beats = min(pixels left in row, MAX_BURST, (4096 - addr[11:0]) / (DATA_W/8)). Set awlen = beats - 1, then go to ADDR.
- ADDR:
  - awvalid = 1; awaddr and awlen stay stable until awready.
  - On the handshake, go to DATA.
  - W beats are never issued before AW is accepted.
- DATA:
  - wvalid = 1; wdata is held until wready.
  - wlast is asserted on beat awlen.
  - The last handshake goes to RESP.
- RESP:
  - bready = 1; on bvalid, bresp[1] = 1 sets err and goes to DONE (abort rest of fill).
  - Otherwise advance x by beats. If the row ends: x = 0, y += 1, row address += cfg_stride.
  - If y == height go to DONE, else go to CALC.
- DONE: done = 1 for exactly one cycle, busy falls in the same cycle, then go to IDLE.
- Pixel function (x, y are zero-based):
  - Solid: cfg_color.
  - Gradient: cfg_color + x, zero-extended, wrapping mod 2^DATA_W.
  - Checker: colour2 when ((x>>CHK_SHIFT) ^ (y>>CHK_SHIFT)) bit 0 is 1, else colour.
- Address arithmetic is mod 2^ADDR_W; wrap-around is not detected.
- Only one burst is outstanding at any time.
- areset mid-fill returns everything to reset values immediately. In-flight AXI transactions are abandoned; the interconnect is reset with the same areset.
- Latency from start to the first awvalid is 2 cycles.

Decomposition:
- Package rect_fill_pkg holds:
  - fill_mode_e enum (SOLID, GRADIENT, CHECKER);
  - fsm state_e;
  - AXI constants BURST_INCR, RESP_SLVERR, and PAGE_BYTES = 4096.
- One sub-module, rect_fill_pixel_gen, is combinational; it maps (mode, x, y, colours) to wdata.
- The top level holds the FSM, counters and burst calculation.

Test Plan:
- Solid fill, base 0x0700_0000, width 20, height 2, stride 0x100, DATA_W 32, MAX_BURST 16.
  - Expect bursts at 0x0700_0000 (len 15), 0x0700_0040 (len 3), 0x0700_0100 (len 15), 0x0700_0140 (len 3).
  - All wdata = colour; one done pulse; err = 0.
- 4 KB split: base 0x0700_0FF0, width 8, height 1.
  - Expect a burst at 0x0700_0FF0 (len 3), then one at 0x0700_1000 (len 3).
- Gradient, colour 0xFFFF_FFFE, width 4: wdata sequence FFFF_FFFE, FFFF_FFFF, 0000_0000, 0000_0001.
- Checkerboard, width 16, height 9, CHK_SHIFT 3.
  - Row 0: 8 × colour then 8 × colour2.
  - Row 8: 8 × colour2 then 8 × colour.
- Error and backpressure:
  - Random awready/wready stalls keep data and address stable.
  - bresp = 2'b10 on the first burst: err = 1, done pulses, no further awvalid.
  - The next start clears err.
- Edge and reset cases:
  - width = 0 → done two cycles after start, no awvalid.
  - start while busy → ignored.
  - areset asserted during DATA → all outputs at reset values on the following cycle.

Source files
------------

// File: rtl/rect_fill_axi_master_pkg.sv
// Shared types and AXI constants for the rectangle fill burst master.
package rect_fill_pkg;

    typedef enum logic [1:0] {
        SOLID    = 2'd0,
        GRADIENT = 2'd1,
        CHECKER  = 2'd2
    } fill_mode_e;

    typedef enum logic [2:0] {
        IDLE,
        CALC,
        ADDR,
        DATA,
        RESP,
        DONE
    } state_e;

    localparam logic [1:0]  BURST_INCR  = 2'b01;
    localparam logic [1:0]  RESP_SLVERR = 2'b10;
    localparam logic [1:0]  RESP_DECERR = 2'b11;
    localparam int unsigned PAGE_BYTES  = 4096;

endpackage

// File: rtl/rect_fill_axi_master_if.sv
// AXI4 write-only channel bundle between the fill master and the interconnect.
interface rect_fill_axi_master_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) ();

    logic [ADDR_W-1:0]   awaddr;
    logic [7:0]          awlen;
    logic [2:0]          awsize;
    logic [1:0]          awburst;
    logic                awvalid;
    logic                awready;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wlast;
    logic                wvalid;
    logic                wready;
    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;

    modport master (
        output awaddr, awlen, awsize, awburst, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bresp, bvalid,
        output bready
    );

    modport slave (
        input  awaddr, awlen, awsize, awburst, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bresp, bvalid,
        input  bready
    );

endinterface

// File: rtl/rect_fill_axi_master_pixel_gen.sv
// Combinational pixel colour for a given (x, y) under the selected fill mode.
module rect_fill_pixel_gen
    import rect_fill_pkg::*;
#(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned DIM_W     = 16,
    parameter int unsigned CHK_SHIFT = 3
) (
    input  logic [1:0]        mode,
    input  logic [DIM_W-1:0]  x,
    input  logic [DIM_W-1:0]  y,
    input  logic [DATA_W-1:0] color,
    input  logic [DATA_W-1:0] color2,
    output logic [DATA_W-1:0] pixel
);

    logic sq_odd;

    always_comb begin
        // (x>>S) ^ (y>>S) equals (x^y)>>S; only its lsb picks the square colour
        sq_odd = 1'((x ^ y) >> CHK_SHIFT);
        pixel  = color;
        case (mode)
            GRADIENT: pixel = color + DATA_W'(x);
            CHECKER:  pixel = sq_odd ? color2 : color;
            default:  pixel = color;
        endcase
    end

endmodule

// File: rtl/rect_fill_axi_master.sv
// AXI4 burst write master filling a rectangle with solid, gradient or checker pixels.
module rect_fill_axi_master
    import rect_fill_pkg::*;
#(
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned MAX_BURST = 16,
    parameter int unsigned DIM_W     = 16,
    parameter int unsigned CHK_SHIFT = 3
) (
    input  logic                  aclk,
    input  logic                  areset,
    input  logic                  start,
    input  logic [ADDR_W-1:0]     cfg_base_addr,
    input  logic [DIM_W-1:0]      cfg_width,
    input  logic [DIM_W-1:0]      cfg_height,
    input  logic [ADDR_W-1:0]     cfg_stride,
    input  logic [1:0]            cfg_mode,
    input  logic [DATA_W-1:0]     cfg_color,
    input  logic [DATA_W-1:0]     cfg_color2,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    rect_fill_axi_master_if.master m_axi
);

    localparam int unsigned BYTES      = DATA_W / 8;
    localparam int unsigned BYTE_SHIFT = $clog2(BYTES);

    state_e             state_q, state_d;
    logic [ADDR_W-1:0]  cur_addr_q, cur_addr_d, row_addr_q, row_addr_d, stride_q, stride_d;
    logic [DIM_W-1:0]   width_q, width_d, height_q, height_d, x_q, x_d, y_q, y_d;
    logic [1:0]         mode_q, mode_d;
    logic [DATA_W-1:0]  color_q, color_d, color2_q, color2_d, wdata_q, wdata_d;
    logic [7:0]         beat_q, beat_d, awlen_q, awlen_d;
    logic [ADDR_W-1:0]  awaddr_q, awaddr_d;
    logic               awvalid_q, awvalid_d, wvalid_q, wvalid_d, wlast_q, wlast_d;
    logic               bready_q, bready_d, busy_q, busy_d, done_q, done_d, err_q, err_d;

    logic [ADDR_W-1:0]  base_al, next_row;
    logic [DIM_W-1:0]   pix_x, row_left, x_adv, y_inc;
    logic [12:0]        page_bytes, page_beats;
    logic [31:0]        beats_calc;
    logic [DATA_W-1:0]  pixel;
    logic               resp_err;

    rect_fill_pixel_gen #(
        .DATA_W    (DATA_W),
        .DIM_W     (DIM_W),
        .CHK_SHIFT (CHK_SHIFT)
    ) u_pixel_gen (
        .mode   (mode_q),
        .x      (pix_x),
        .y      (y_q),
        .color  (color_q),
        .color2 (color2_q),
        .pixel  (pixel)
    );

    always_comb begin
        base_al    = cfg_base_addr & ~ADDR_W'(BYTES - 1);
        next_row   = row_addr_q + stride_q;
        // ADDR prepares beat 0; in DATA the next beat's pixel is prepared
        pix_x      = (state_q == ADDR) ? x_q : x_q + DIM_W'(beat_q) + DIM_W'(1);
        row_left   = width_q - x_q;
        x_adv      = x_q + DIM_W'(awlen_q) + DIM_W'(1);
        y_inc      = y_q + DIM_W'(1);
        page_bytes = 13'(PAGE_BYTES) - {1'b0, cur_addr_q[11:0]};
        page_beats = page_bytes >> BYTE_SHIFT;
        beats_calc = 32'(row_left);
        if (MAX_BURST < beats_calc)
            beats_calc = MAX_BURST;
        if (32'(page_beats) < beats_calc)
            beats_calc = 32'(page_beats);
        resp_err   = m_axi.bresp inside {RESP_SLVERR, RESP_DECERR};

        state_d    = state_q;
        cur_addr_d = cur_addr_q;
        row_addr_d = row_addr_q;
        stride_d   = stride_q;
        width_d    = width_q;
        height_d   = height_q;
        x_d        = x_q;
        y_d        = y_q;
        mode_d     = mode_q;
        color_d    = color_q;
        color2_d   = color2_q;
        wdata_d    = wdata_q;
        beat_d     = beat_q;
        awlen_d    = awlen_q;
        awaddr_d   = awaddr_q;
        awvalid_d  = awvalid_q;
        wvalid_d   = wvalid_q;
        wlast_d    = wlast_q;
        bready_d   = bready_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        err_d      = err_q;

        case (state_q)
            IDLE: if (start) begin
                cur_addr_d = base_al;
                row_addr_d = base_al;
                stride_d   = cfg_stride;
                width_d    = cfg_width;
                height_d   = cfg_height;
                mode_d     = cfg_mode;
                color_d    = cfg_color;
                color2_d   = cfg_color2;
                x_d        = '0;
                y_d        = '0;
                err_d      = 1'b0;
                busy_d     = 1'b1;
                state_d    = (cfg_width == '0 || cfg_height == '0) ? DONE : CALC;
            end
            CALC: begin
                awaddr_d  = cur_addr_q;
                awlen_d   = 8'(beats_calc - 32'd1);
                awvalid_d = 1'b1;
                state_d   = ADDR;
            end
            ADDR: if (m_axi.awready) begin
                awvalid_d = 1'b0;
                wvalid_d  = 1'b1;
                wdata_d   = pixel;
                wlast_d   = (awlen_q == 8'd0);
                beat_d    = '0;
                state_d   = DATA;
            end
            DATA: if (m_axi.wready) begin
                if (wlast_q) begin
                    wvalid_d = 1'b0;
                    wlast_d  = 1'b0;
                    bready_d = 1'b1;
                    state_d  = RESP;
                end else begin
                    beat_d  = beat_q + 8'd1;
                    wdata_d = pixel;
                    wlast_d = (beat_q + 8'd1 == awlen_q);
                end
            end
            RESP: if (m_axi.bvalid) begin
                bready_d = 1'b0;
                if (resp_err) begin
                    err_d   = 1'b1;
                    state_d = DONE;
                end else if (x_adv == width_q) begin
                    x_d        = '0;
                    y_d        = y_inc;
                    row_addr_d = next_row;
                    cur_addr_d = next_row;
                    state_d    = (y_inc == height_q) ? DONE : CALC;
                end else begin
                    x_d        = x_adv;
                    cur_addr_d = cur_addr_q + ((ADDR_W'(awlen_q) + ADDR_W'(1)) << BYTE_SHIFT);
                    state_d    = CALC;
                end
            end
            DONE: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q    <= IDLE;
            cur_addr_q <= '0;
            row_addr_q <= '0;
            stride_q   <= '0;
            width_q    <= '0;
            height_q   <= '0;
            x_q        <= '0;
            y_q        <= '0;
            mode_q     <= '0;
            color_q    <= '0;
            color2_q   <= '0;
            wdata_q    <= '0;
            beat_q     <= '0;
            awlen_q    <= '0;
            awaddr_q   <= '0;
            awvalid_q  <= 1'b0;
            wvalid_q   <= 1'b0;
            wlast_q    <= 1'b0;
            bready_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cur_addr_q <= cur_addr_d;
            row_addr_q <= row_addr_d;
            stride_q   <= stride_d;
            width_q    <= width_d;
            height_q   <= height_d;
            x_q        <= x_d;
            y_q        <= y_d;
            mode_q     <= mode_d;
            color_q    <= color_d;
            color2_q   <= color2_d;
            wdata_q    <= wdata_d;
            beat_q     <= beat_d;
            awlen_q    <= awlen_d;
            awaddr_q   <= awaddr_d;
            awvalid_q  <= awvalid_d;
            wvalid_q   <= wvalid_d;
            wlast_q    <= wlast_d;
            bready_q   <= bready_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign busy          = busy_q;
    assign done          = done_q;
    assign err           = err_q;
    assign m_axi.awaddr  = awaddr_q;
    assign m_axi.awlen   = awlen_q;
    assign m_axi.awsize  = 3'(BYTE_SHIFT);
    assign m_axi.awburst = BURST_INCR;
    assign m_axi.awvalid = awvalid_q;
    assign m_axi.wdata   = wdata_q;
    assign m_axi.wstrb   = '1;
    assign m_axi.wlast   = wlast_q;
    assign m_axi.wvalid  = wvalid_q;
    assign m_axi.bready  = bready_q;

endmodule

// File: tb/tb_rect_fill_axi_master.sv
// Directed bench: AXI slave model with optional stalls/error injection, expected bursts hand-derived.
module tb_rect_fill_axi_master;

    logic        aclk = 1'b0;
    logic        areset = 1'b1;
    logic        start = 1'b0;
    logic [31:0] cfg_base_addr = '0;
    logic [15:0] cfg_width = '0;
    logic [15:0] cfg_height = '0;
    logic [31:0] cfg_stride = '0;
    logic [1:0]  cfg_mode = '0;
    logic [31:0] cfg_color = '0;
    logic [31:0] cfg_color2 = '0;
    logic        busy, done, err;

    rect_fill_axi_master_if #(.ADDR_W(32), .DATA_W(32)) axi ();

    rect_fill_axi_master #(
        .ADDR_W    (32),
        .DATA_W    (32),
        .MAX_BURST (16),
        .DIM_W     (16),
        .CHK_SHIFT (3)
    ) dut (
        .aclk          (aclk),
        .areset        (areset),
        .start         (start),
        .cfg_base_addr (cfg_base_addr),
        .cfg_width     (cfg_width),
        .cfg_height    (cfg_height),
        .cfg_stride    (cfg_stride),
        .cfg_mode      (cfg_mode),
        .cfg_color     (cfg_color),
        .cfg_color2    (cfg_color2),
        .busy          (busy),
        .done          (done),
        .err           (err),
        .m_axi         (axi)
    );

    always #5 aclk = ~aclk;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] aw_addr_q[$];
    logic [7:0]  aw_len_q[$];
    logic [31:0] wd_q[$];
    int          done_cnt = 0;
    bit          stall_en = 0;
    int          err_at = -1;
    int          b_idx = 0;
    int          aw_pend = 0;
    bit          w_last_hs = 0, b_hs = 0, aw_hold = 0, w_hold = 0;
    logic [31:0] hold_addr, hold_data;
    logic [7:0]  hold_len;
    logic        hold_last;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Slave + monitor: decisions at negedge take effect at the following posedge.
    initial begin
        axi.awready = 1'b0;
        axi.wready  = 1'b0;
        axi.bvalid  = 1'b0;
        axi.bresp   = 2'b00;
        forever begin
            @(negedge aclk);
            if (areset) begin
                axi.awready = 1'b0;
                axi.wready  = 1'b0;
                axi.bvalid  = 1'b0;
                w_last_hs = 0; b_hs = 0; aw_hold = 0; w_hold = 0; aw_pend = 0;
            end else begin
                if (b_hs) begin axi.bvalid = 1'b0; b_hs = 0; end
                if (w_last_hs) begin
                    axi.bvalid = 1'b1;
                    axi.bresp  = (b_idx == err_at) ? 2'b10 : 2'b00;
                    b_idx++;
                    w_last_hs = 0;
                end
                axi.awready = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
                axi.wready  = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
                if (aw_hold)
                    check_val("aw_stable", {axi.awvalid, axi.awaddr, axi.awlen}, {1'b1, hold_addr, hold_len});
                if (w_hold)
                    check_val("w_stable", {axi.wvalid, axi.wlast, axi.wdata}, {1'b1, hold_last, hold_data});
                aw_hold = axi.awvalid && !axi.awready;
                hold_addr = axi.awaddr; hold_len = axi.awlen;
                w_hold = axi.wvalid && !axi.wready;
                hold_last = axi.wlast; hold_data = axi.wdata;
                if (axi.wvalid && axi.wready) begin
                    check_val("w_after_aw", aw_pend, 1);
                    wd_q.push_back(axi.wdata);
                    if (axi.wlast) begin w_last_hs = 1; aw_pend--; end
                end
                if (axi.awvalid && axi.awready) begin
                    aw_addr_q.push_back(axi.awaddr);
                    aw_len_q.push_back(axi.awlen);
                    aw_pend++;
                end
                if (axi.bvalid && axi.bready) b_hs = 1;
                if (done) done_cnt++;
            end
        end
    end

    task automatic launch(input logic [31:0] base, input logic [15:0] w, input logic [15:0] h,
                          input logic [31:0] stride, input logic [1:0] mode,
                          input logic [31:0] c1, input logic [31:0] c2);
        @(negedge aclk);
        aw_addr_q.delete(); aw_len_q.delete(); wd_q.delete();
        done_cnt = 0; b_idx = 0;
        cfg_base_addr = base; cfg_width = w; cfg_height = h; cfg_stride = stride;
        cfg_mode = mode; cfg_color = c1; cfg_color2 = c2;
        start = 1'b1;
        @(negedge aclk);
        start = 1'b0;
        check_val("busy_after_start", busy, 1);
        check_val("err_cleared", err, 0);
    endtask

    task automatic wait_done();
        int unsigned cyc = 0;
        while (!done && cyc < 3000) begin @(negedge aclk); cyc++; end
        check_val("done_seen", done, 1);
        check_val("busy_low_at_done", busy, 0);
        @(negedge aclk);
        check_val("done_one_cycle", done, 0);
        repeat (3) @(negedge aclk);
        check_val("done_count", done_cnt, 1);
    endtask

    task automatic check_idle_outputs(input string ctx);
        check_val({ctx, "_busy"}, busy, 0);
        check_val({ctx, "_done"}, done, 0);
        check_val({ctx, "_err"}, err, 0);
        check_val({ctx, "_awvalid"}, axi.awvalid, 0);
        check_val({ctx, "_wvalid"}, axi.wvalid, 0);
        check_val({ctx, "_wlast"}, axi.wlast, 0);
        check_val({ctx, "_bready"}, axi.bready, 0);
        check_val({ctx, "_awaddr"}, axi.awaddr, 0);
        check_val({ctx, "_awlen"}, axi.awlen, 0);
        check_val({ctx, "_wdata"}, axi.wdata, 0);
    endtask

    task automatic check_solid_20x2(input logic [31:0] col);
        logic [31:0] ea[4];
        logic [7:0]  el[4];
        ea = '{32'h0700_0000, 32'h0700_0040, 32'h0700_0100, 32'h0700_0140};
        el = '{8'd15, 8'd3, 8'd15, 8'd3};
        check_val("solid_aw_count", aw_addr_q.size(), 4);
        for (int i = 0; i < 4; i++) begin
            check_val("solid_awaddr", aw_addr_q[i], ea[i]);
            check_val("solid_awlen", aw_len_q[i], el[i]);
        end
        check_val("solid_w_count", wd_q.size(), 40);
        for (int i = 0; i < 40; i++) check_val("solid_wdata", wd_q[i], col);
        check_val("solid_err", err, 0);
    endtask

    initial begin
        logic [31:0] grad[4];
        int unsigned cyc;

        repeat (3) @(negedge aclk);
        check_idle_outputs("reset");
        check_val("awsize", axi.awsize, 3'd2);
        check_val("awburst", axi.awburst, 2'b01);
        check_val("wstrb", axi.wstrb, 4'hF);
        areset = 1'b0;

        // Solid, row split by MAX_BURST
        launch(32'h0700_0000, 16'd20, 16'd2, 32'h100, 2'd0, 32'hA5A5_5A5A, 32'h0);
        wait_done();
        check_solid_20x2(32'hA5A5_5A5A);

        // 4 KB page split
        launch(32'h0700_0FF0, 16'd8, 16'd1, 32'h100, 2'd3, 32'h1234_5678, 32'h0);
        wait_done();
        check_val("split_aw_count", aw_addr_q.size(), 2);
        check_val("split_awaddr0", aw_addr_q[0], 32'h0700_0FF0);
        check_val("split_awlen0", aw_len_q[0], 8'd3);
        check_val("split_awaddr1", aw_addr_q[1], 32'h0700_1000);
        check_val("split_awlen1", aw_len_q[1], 8'd3);
        check_val("split_w_count", wd_q.size(), 8);
        for (int i = 0; i < 8; i++) check_val("split_wdata", wd_q[i], 32'h1234_5678);

        // Gradient wrap
        launch(32'h0700_2000, 16'd4, 16'd1, 32'h100, 2'd1, 32'hFFFF_FFFE, 32'h0);
        wait_done();
        grad = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001};
        check_val("grad_aw_count", aw_addr_q.size(), 1);
        check_val("grad_awlen", aw_len_q[0], 8'd3);
        check_val("grad_w_count", wd_q.size(), 4);
        for (int i = 0; i < 4; i++) check_val("grad_wdata", wd_q[i], grad[i]);

        // Checkerboard 16x9, 8-pixel squares
        launch(32'h0701_0000, 16'd16, 16'd9, 32'h40, 2'd2, 32'hAAAA_0000, 32'h0000_5555);
        wait_done();
        check_val("chk_aw_count", aw_addr_q.size(), 9);
        for (int r = 0; r < 9; r++) begin
            check_val("chk_awaddr", aw_addr_q[r], 32'h0701_0000 + 32'(r) * 32'h40);
            check_val("chk_awlen", aw_len_q[r], 8'd15);
        end
        check_val("chk_w_count", wd_q.size(), 144);
        for (int r = 0; r < 9; r++)
            for (int c = 0; c < 16; c++)
                check_val("chk_wdata", wd_q[r * 16 + c],
                          ((r < 8) == (c < 8)) ? 32'hAAAA_0000 : 32'h0000_5555);

        // SLVERR on first burst under backpressure aborts the fill
        stall_en = 1; err_at = 0;
        launch(32'h0700_0000, 16'd20, 16'd2, 32'h100, 2'd0, 32'hC0FF_EE00, 32'h0);
        wait_done();
        check_val("error_err", err, 1);
        check_val("error_aw_count", aw_addr_q.size(), 1);
        check_val("error_w_count", wd_q.size(), 16);
        check_val("error_awvalid_after", axi.awvalid, 0);

        // Next start clears err (checked in launch), stalls keep data intact
        err_at = -1;
        launch(32'h0700_0000, 16'd20, 16'd2, 32'h100, 2'd0, 32'h0BAD_F00D, 32'h0);
        wait_done();
        check_solid_20x2(32'h0BAD_F00D);
        stall_en = 0;

        // Zero width: done exactly two cycles after start, no traffic
        launch(32'h0700_0000, 16'd0, 16'd5, 32'h100, 2'd0, 32'h1, 32'h0);
        check_val("zero_done_early", done, 0);
        @(negedge aclk);
        check_val("zero_done_latency", done, 1);
        check_val("zero_busy_low", busy, 0);
        @(negedge aclk);
        check_val("zero_done_pulse", done, 0);
        check_val("zero_aw_count", aw_addr_q.size(), 0);

        // Start while busy is ignored
        launch(32'h0700_3000, 16'd4, 16'd1, 32'h100, 2'd1, 32'h10, 32'h0);
        @(negedge aclk);
        cfg_base_addr = 32'h0800_0000; cfg_width = 16'd1; cfg_mode = 2'd0;
        start = 1'b1;
        @(negedge aclk);
        start = 1'b0;
        wait_done();
        check_val("busy_start_aw_count", aw_addr_q.size(), 1);
        check_val("busy_start_awaddr", aw_addr_q[0], 32'h0700_3000);
        check_val("busy_start_awlen", aw_len_q[0], 8'd3);
        check_val("busy_start_w_count", wd_q.size(), 4);
        for (int i = 0; i < 4; i++) check_val("busy_start_wdata", wd_q[i], 32'h10 + 32'(i));

        // Reset in the middle of the data phase
        launch(32'h0700_0000, 16'd20, 16'd2, 32'h100, 2'd0, 32'h7777_7777, 32'h0);
        cyc = 0;
        while (!axi.wvalid && cyc < 50) begin @(negedge aclk); cyc++; end
        check_val("reset_reached_data", axi.wvalid, 1);
        areset = 1'b1;
        @(negedge aclk);
        check_idle_outputs("midreset");
        @(negedge aclk);
        areset = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
